// File: rtl/dmac_arb_pkg.sv
// Shared types and constants for the DMA write-port arbiter.
package dmac_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2
  } arb_state_e;

  localparam int                   OUTST_W   = 4;
  localparam logic [OUTST_W-1:0]   OUTST_MAX = 4'd15;

  // AXI ID width wide enough to carry a channel index.
  function automatic int id_w_default(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Round-robin winner search: scan starts one past the last served channel.
module dmac_rr_picker #(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_win,
  output logic             o_found
);

  always_comb begin
    logic [IDX_W-1:0] w_cand;
    o_win   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = IDX_W'((int'(i_last) + k) % N_CH);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_win   = w_cand;
      end
    end
  end

endmodule

// File: rtl/dmac_wr_arbiter.sv
// Multiplexes N_CH DMA write engines onto one AXI write port, one whole burst
// (AW then all W beats) per grant; B responses are routed back by ID.
module dmac_wr_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = id_w_default(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0][31:0] ch_awaddr_i,
  input  logic [N_CH-1:0][3:0]  ch_awlen_i,
  input  logic [N_CH-1:0][2:0]  ch_awsize_i,
  input  logic [N_CH-1:0][1:0]  ch_awburst_i,
  input  logic [N_CH-1:0]       ch_awvalid_i,
  output logic [N_CH-1:0]       ch_awready_o,
  input  logic [N_CH-1:0][31:0] ch_wdata_i,
  input  logic [N_CH-1:0][3:0]  ch_wstrb_i,
  input  logic [N_CH-1:0]       ch_wlast_i,
  input  logic [N_CH-1:0]       ch_wvalid_i,
  output logic [N_CH-1:0]       ch_wready_o,
  output logic [N_CH-1:0][1:0]  ch_bresp_o,
  output logic [N_CH-1:0]       ch_bvalid_o,
  input  logic [N_CH-1:0]       ch_bready_i,
  output logic [ID_W-1:0]       awid_o,
  output logic [31:0]           awaddr_o,
  output logic [3:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ID_W-1:0]       wid_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [ID_W-1:0]       bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [N_CH-1:0]       grant_o,
  output logic                  proto_err_o
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int BEAT_W = 5;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_last_served;
  logic [N_CH-1:0]  r_grant;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [3:0]       r_awlen;
  logic             r_proto_err;

  logic [N_CH-1:0]   w_elig;
  logic [N_CH-1:0]   w_aw_inc;
  logic [N_CH-1:0]   w_b_dec;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_found;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_bid_ok;
  logic              w_bid_err;
  logic [BEAT_W-1:0] w_beat_num;
  logic [BEAT_W-1:0] w_beat_len;

  assign w_aw_hs    = awvalid_o & awready_i;
  assign w_w_hs     = wvalid_o & wready_i;
  assign w_bid_ok   = (32'(bid_i) < 32'(N_CH));
  assign w_bid_err  = bvalid_i & ~w_bid_ok;
  assign w_beat_num = r_beat_cnt + 5'd1;
  assign w_beat_len = {1'b0, r_awlen} + 5'd1;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [OUTST_W-1:0] r_outst;

      // A channel with 15 bursts awaiting B is not eligible until one returns.
      assign w_elig[gi]      = ch_awvalid_i[gi] & (r_outst != OUTST_MAX);
      assign w_aw_inc[gi]    = w_aw_hs & r_grant[gi];
      assign ch_bvalid_o[gi] = bvalid_i & (bid_i == ID_W'(gi));
      assign ch_bresp_o[gi]  = (bid_i == ID_W'(gi)) ? bresp_i : 2'b00;
      assign w_b_dec[gi]     = ch_bvalid_o[gi] & ch_bready_i[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_outst <= '0;
        end else if (w_aw_inc[gi] && !w_b_dec[gi] && (r_outst != OUTST_MAX)) begin
          r_outst <= r_outst + 1'b1;
        end else if (!w_aw_inc[gi] && w_b_dec[gi] && (r_outst != '0)) begin
          r_outst <= r_outst - 1'b1;
        end
      end
    end
  endgenerate

  // Unknown IDs are sunk so the interconnect never stalls on them.
  always_comb begin
    bready_o = ~w_bid_ok;
    for (int c = 0; c < N_CH; c++) begin
      if (bid_i == ID_W'(c)) bready_o = ch_bready_i[c];
    end
  end

  dmac_rr_picker #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (w_elig),
    .i_last  (r_last_served),
    .o_win   (w_win_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_idx   <= '0;
      r_grant       <= '0;
      r_last_served <= IDX_W'(N_CH - 1);
      r_beat_cnt    <= '0;
      r_awlen       <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_bid_err) r_proto_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_win_idx;
            r_grant     <= N_CH'(1) << w_win_idx;
            r_state     <= S_AW;
          end
        end
        S_AW: begin
          if (w_aw_hs) begin
            r_awlen    <= awlen_o;
            r_beat_cnt <= '0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            r_beat_cnt <= w_beat_num;
            if ((wlast_o && (w_beat_num < w_beat_len)) ||
                (!wlast_o && (w_beat_num == w_beat_len))) begin
              r_proto_err <= 1'b1;
            end
            if (wlast_o) begin
              r_state       <= S_IDLE;
              r_grant       <= '0;
              r_last_served <= r_grant_idx;
              r_beat_cnt    <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    awvalid_o    = 1'b0;
    awid_o       = '0;
    awaddr_o     = '0;
    awlen_o      = '0;
    awsize_o     = '0;
    awburst_o    = '0;
    wvalid_o     = 1'b0;
    wid_o        = '0;
    wdata_o      = '0;
    wstrb_o      = '0;
    wlast_o      = 1'b0;
    ch_awready_o = '0;
    ch_wready_o  = '0;
    case (r_state)
      S_AW: begin
        awvalid_o    = 1'b1;
        awid_o       = ID_W'(r_grant_idx);
        awaddr_o     = ch_awaddr_i[r_grant_idx];
        awlen_o      = ch_awlen_i[r_grant_idx];
        awsize_o     = ch_awsize_i[r_grant_idx];
        awburst_o    = ch_awburst_i[r_grant_idx];
        ch_awready_o = r_grant & {N_CH{awready_i}};
      end
      S_W: begin
        wvalid_o    = ch_wvalid_i[r_grant_idx];
        wid_o       = ID_W'(r_grant_idx);
        wdata_o     = ch_wdata_i[r_grant_idx];
        wstrb_o     = ch_wstrb_i[r_grant_idx];
        wlast_o     = ch_wlast_i[r_grant_idx];
        ch_wready_o = r_grant & {N_CH{wready_i}};
      end
      default: ;
    endcase
  end

  assign grant_o     = r_grant;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_dmac_wr_arbiter.sv
// Directed bench for dmac_wr_arbiter: B-routing vector table plus burst sequences.
module tb_dmac_wr_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][31:0] ch_awaddr_i;
  logic [3:0][3:0]  ch_awlen_i;
  logic [3:0][2:0]  ch_awsize_i;
  logic [3:0][1:0]  ch_awburst_i;
  logic [3:0]       ch_awvalid_i;
  logic [3:0]       ch_awready_o;
  logic [3:0][31:0] ch_wdata_i;
  logic [3:0][3:0]  ch_wstrb_i;
  logic [3:0]       ch_wlast_i;
  logic [3:0]       ch_wvalid_i;
  logic [3:0]       ch_wready_o;
  logic [3:0][1:0]  ch_bresp_o;
  logic [3:0]       ch_bvalid_o;
  logic [3:0]       ch_bready_i;
  logic [2:0]       awid_o;
  logic [31:0]      awaddr_o;
  logic [3:0]       awlen_o;
  logic [2:0]       awsize_o;
  logic [1:0]       awburst_o;
  logic             awvalid_o;
  logic             awready_i;
  logic [2:0]       wid_o;
  logic [31:0]      wdata_o;
  logic [3:0]       wstrb_o;
  logic             wlast_o;
  logic             wvalid_o;
  logic             wready_i;
  logic [2:0]       bid_i;
  logic [1:0]       bresp_i;
  logic             bvalid_i;
  logic             bready_o;
  logic [3:0]       grant_o;
  logic             proto_err_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmac_wr_arbiter #(.N_CH(4), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_awaddr_i(ch_awaddr_i), .ch_awlen_i(ch_awlen_i), .ch_awsize_i(ch_awsize_i),
    .ch_awburst_i(ch_awburst_i), .ch_awvalid_i(ch_awvalid_i), .ch_awready_o(ch_awready_o),
    .ch_wdata_i(ch_wdata_i), .ch_wstrb_i(ch_wstrb_i), .ch_wlast_i(ch_wlast_i),
    .ch_wvalid_i(ch_wvalid_i), .ch_wready_o(ch_wready_o),
    .ch_bresp_o(ch_bresp_o), .ch_bvalid_o(ch_bvalid_o), .ch_bready_i(ch_bready_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .grant_o(grant_o), .proto_err_o(proto_err_o)
  );

  typedef struct packed {
    logic [2:0] bid;
    logic [1:0] bresp;
    logic       bvalid;
    logic [3:0] chbready;
    logic [3:0] exp_bvalid;
    logic [7:0] exp_bresp;
    logic       exp_bready;
    logic       exp_err;
  } bvec_t;

  bvec_t bv [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int ch);
    return 32'h1000_0000 + 32'(ch) * 32'h100;
  endfunction

  function automatic logic [31:0] wpat(input int ch, input int b);
    return {8'(ch), 8'(b), 16'hA55A};
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    ch_awvalid_i = '0;
    ch_wvalid_i  = '0;
    ch_wlast_i   = '0;
    awready_i    = 1'b0;
    wready_i     = 1'b0;
    bvalid_i     = 1'b0;
    bid_i        = '0;
    bresp_i      = '0;
    ch_bready_i  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_awaddr", awaddr_o, 0);
    chk("rst_err", proto_err_o, 0);
    $display("reset applied");
  endtask

  // Wait for AW from channel ch, optionally stall awready, then handshake.
  task automatic aw_phase(input int ch, input logic [3:0] exp_len, input int stall,
                          input int max_wait, input bit drop);
    int cyc = 0;
    #1;
    while (awvalid_o !== 1'b1 && cyc < max_wait) begin
      tick();
      cyc++;
    end
    chk("aw_valid", awvalid_o, 1);
    chk("aw_id", awid_o, ch);
    chk("aw_grant", grant_o, 64'd1 << ch);
    chk("aw_addr", awaddr_o, addr_of(ch));
    chk("aw_len", awlen_o, exp_len);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_awvalid", awvalid_o, 1);
      chk("stall_awready", ch_awready_o, 0);
      chk("stall_addr", awaddr_o, addr_of(ch));
      chk("stall_len", awlen_o, exp_len);
    end
    awready_i = 1'b1;
    #1;
    chk("aw_chready", ch_awready_o, 64'd1 << ch);
    tick();
    awready_i = 1'b0;
    if (drop) ch_awvalid_i[ch] = 1'b0;
    $display("AW ch%0d addr=%08h len=%0d waited=%0d", ch, addr_of(ch), exp_len, cyc);
  endtask

  // Drive nbeats W beats on channel ch; wlast on beat last_at (1-based).
  task automatic w_beats(input int ch, input int nbeats, input int last_at, input bit inject_b);
    for (int b = 0; b < nbeats; b++) begin
      ch_wvalid_i[ch] = 1'b1;
      ch_wlast_i[ch]  = (b == last_at - 1);
      ch_wdata_i[ch]  = wpat(ch, b);
      wready_i        = 1'b1;
      if (inject_b && b == 1) begin
        bvalid_i    = 1'b1;
        bid_i       = 3'd3;
        bresp_i     = 2'b10;
        ch_bready_i = 4'b1000;
      end
      #1;
      chk("w_valid", wvalid_o, 1);
      chk("w_id", wid_o, ch);
      chk("w_data", wdata_o, wpat(ch, b));
      chk("w_last", wlast_o, (b == last_at - 1));
      chk("w_chready", ch_wready_o, 64'd1 << ch);
      if (inject_b && b == 1) begin
        chk("b_mid_bvalid", ch_bvalid_o, 4'b1000);
        chk("b_mid_bresp", ch_bresp_o, 8'h80);
        chk("b_mid_bready", bready_o, 1);
      end
      tick();
      bvalid_i    = 1'b0;
      ch_bready_i = '0;
    end
    ch_wvalid_i[ch] = 1'b0;
    ch_wlast_i[ch]  = 1'b0;
    wready_i        = 1'b0;
    $display("W ch%0d beats=%0d", ch, nbeats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      ch_awaddr_i[c]  = addr_of(c);
      ch_awsize_i[c]  = 3'd2;
      ch_awburst_i[c] = 2'b01;
      ch_awlen_i[c]   = 4'd0;
      ch_wdata_i[c]   = '0;
      ch_wstrb_i[c]   = 4'hF;
    end

    //         bid   bresp  bv    chbrdy   exp_bv   exp_bresp     bready err
    bv[0] = '{3'd0, 2'b01, 1'b1, 4'b0001, 4'b0001, 8'b00000001, 1'b1, 1'b0};
    bv[1] = '{3'd2, 2'b11, 1'b1, 4'b0001, 4'b0100, 8'b00110000, 1'b0, 1'b0};
    bv[2] = '{3'd3, 2'b10, 1'b1, 4'b1000, 4'b1000, 8'b10000000, 1'b1, 1'b0};
    bv[3] = '{3'd1, 2'b11, 1'b0, 4'b0010, 4'b0000, 8'b00001100, 1'b1, 1'b0};
    bv[4] = '{3'd1, 2'b10, 1'b1, 4'b1101, 4'b0010, 8'b00001000, 1'b0, 1'b0};
    bv[5] = '{3'd5, 2'b10, 1'b1, 4'b0000, 4'b0000, 8'b00000000, 1'b1, 1'b1};
    bv[6] = '{3'd2, 2'b01, 1'b1, 4'b0100, 4'b0100, 8'b00010000, 1'b1, 1'b1};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      bid_i       = bv[i].bid;
      bresp_i     = bv[i].bresp;
      bvalid_i    = bv[i].bvalid;
      ch_bready_i = bv[i].chbready;
      #1;
      chk($sformatf("bvec%0d_bvalid", i), ch_bvalid_o, bv[i].exp_bvalid);
      chk($sformatf("bvec%0d_bresp", i), ch_bresp_o, bv[i].exp_bresp);
      chk($sformatf("bvec%0d_bready", i), bready_o, bv[i].exp_bready);
      tick();
      chk($sformatf("bvec%0d_err", i), proto_err_o, bv[i].exp_err);
      $display("B vec %0d bid=%0d bresp=%0d bvalid=%0d", i, bv[i].bid, bv[i].bresp, bv[i].bvalid);
    end
    bvalid_i    = 1'b0;
    ch_bready_i = '0;

    // Simultaneous ch0/ch2 requests: ch0 first, one idle cycle, then ch2.
    do_reset();
    ch_awlen_i[0] = 4'd3;
    ch_awlen_i[2] = 4'd3;
    ch_awvalid_i[0] = 1'b1;
    ch_awvalid_i[2] = 1'b1;
    aw_phase(0, 4'd3, 0, 1, 1);
    w_beats(0, 4, 4, 0);
    #1;
    chk("gap_awvalid", awvalid_o, 0);
    chk("gap_grant", grant_o, 0);
    aw_phase(2, 4'd3, 0, 1, 1);
    w_beats(2, 4, 4, 0);
    chk("clean_err", proto_err_o, 0);

    // All channels requesting 1-beat bursts: strict rotation.
    do_reset();
    for (int c = 0; c < 4; c++) ch_awlen_i[c] = 4'd0;
    ch_awvalid_i = 4'hF;
    for (int i = 0; i < 16; i++) begin
      aw_phase(i % 4, 4'd0, 0, 1, 0);
      w_beats(i % 4, 1, 1, 0);
    end
    ch_awvalid_i = '0;

    // AW stall of 5 cycles, then a burst with a foreign B mid-traffic.
    do_reset();
    ch_awlen_i[1] = 4'd1;
    ch_awvalid_i[1] = 1'b1;
    aw_phase(1, 4'd1, 5, 1, 1);
    w_beats(1, 2, 2, 0);
    ch_awlen_i[1] = 4'd3;
    ch_awvalid_i[1] = 1'b1;
    aw_phase(1, 4'd3, 0, 1, 1);
    w_beats(1, 4, 4, 1);
    chk("bmid_err", proto_err_o, 0);

    // Early wlast flags a protocol error.
    do_reset();
    ch_awlen_i[2] = 4'd3;
    ch_awvalid_i[2] = 1'b1;
    aw_phase(2, 4'd3, 0, 1, 1);
    w_beats(2, 2, 2, 0);
    chk("err_early_wlast", proto_err_o, 1);

    // Missing wlast on the final counted beat flags a protocol error.
    do_reset();
    ch_awlen_i[3] = 4'd0;
    ch_awvalid_i[3] = 1'b1;
    aw_phase(3, 4'd0, 0, 1, 1);
    w_beats(3, 2, 2, 0);
    chk("err_late_wlast", proto_err_o, 1);

    // Outstanding limit: 15 AWs without B block ch1 until one B returns.
    do_reset();
    ch_awlen_i[1] = 4'd0;
    ch_awvalid_i[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      aw_phase(1, 4'd0, 0, 1, 0);
      w_beats(1, 1, 1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("blocked_awvalid", awvalid_o, 0);
      chk("blocked_grant", grant_o, 0);
    end
    bvalid_i    = 1'b1;
    bid_i       = 3'd1;
    bresp_i     = 2'b00;
    ch_bready_i = 4'b0010;
    #1;
    chk("unblock_bvalid", ch_bvalid_o, 4'b0010);
    chk("unblock_bready", bready_o, 1);
    tick();
    bvalid_i    = 1'b0;
    ch_bready_i = '0;
    aw_phase(1, 4'd0, 0, 1, 1);
    w_beats(1, 1, 1, 0);

    // Reset during beat 3 of a 16-beat burst; ch0 must win afterwards.
    do_reset();
    ch_awlen_i[0] = 4'd0;
    ch_awlen_i[1] = 4'd15;
    ch_awvalid_i[0] = 1'b1;
    ch_awvalid_i[1] = 1'b1;
    aw_phase(0, 4'd0, 0, 1, 0);
    w_beats(0, 1, 1, 0);
    aw_phase(1, 4'd15, 0, 1, 0);
    w_beats(1, 2, 16, 0);
    ch_wvalid_i[1] = 1'b1;
    ch_wdata_i[1]  = wpat(1, 2);
    wready_i       = 1'b1;
    #1;
    chk("beat3_wvalid", wvalid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_awvalid", awvalid_o, 0);
    chk("midrst_wvalid", wvalid_o, 0);
    chk("midrst_grant", grant_o, 0);
    chk("midrst_wready", ch_wready_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("postrst_awvalid", awvalid_o, 0);
    chk("postrst_wvalid", wvalid_o, 0);
    ch_wvalid_i[1] = 1'b0;
    wready_i       = 1'b0;
    aw_phase(0, 4'd0, 0, 1, 1);
    w_beats(0, 1, 1, 0);
    ch_awvalid_i = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
